// File: rtl/cpu_clock_ctrl_pkg.sv
// rtl/cpu_clock_ctrl_pkg.sv - shared types and default constants for the CPU clock controller
//
// Purpose: state encoding and parameter defaults used by cpu_clock_ctrl.
// Ports:   none (package).
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        STEP   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } clk_state_t;

    localparam int DEF_RUN_DIV       = 12000000;
    localparam int DEF_REPEAT_DELAY  = 6000000;
    localparam int DEF_REPEAT_PERIOD = 1200000;

endpackage

// File: rtl/cpu_clock_ctrl_edge_detect.sv
// rtl/cpu_clock_ctrl_edge_detect.sv - one-cycle rising-edge pulse from a level input
//
// Purpose: flags the first cycle a level input is high. History resets to 1 so
//          a level held through reset does not register as a press.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   i_level  in  debounced level, synchronous to clk
//   o_edge   out combinational rising-edge pulse
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_edge
);

    logic r_level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= 1'b1;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_edge = i_level & ~r_level_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - clock-enable sequencer for the 8-bit CPU (step / run / halt)
//
// Purpose: issues single-cycle cpu_ce pulses from the step button, from a run-mode
//          divider, and stops permanently on HLT until reset.
// Optional: macro STEP_AUTOREPEAT_EN adds step-button auto-repeat in STEP mode.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   btn_step    in  debounced step button level
//   btn_mode    in  debounced mode button level (press toggles step/run)
//   halt_in     in  CPU HLT line
//   cpu_ce      out registered one-cycle enable to the CPU
//   run_mode    out 1 = free-run
//   halted      out 1 = halt latched
//   step_count  out wrapping count of cpu_ce pulses
module cpu_clock_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH     = 24,
    parameter int RUN_DIV       = DEF_RUN_DIV,
    parameter int CNT_WIDTH     = 16
`ifdef STEP_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 btn_mode,
    input  logic                 halt_in,
    output logic                 cpu_ce,
    output logic                 run_mode,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] step_count
);

    localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(RUN_DIV - 1);

    clk_state_t            r_state;
    clk_state_t            w_next_state;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  w_div_next;
    logic                  w_pulse;
    logic                  r_cpu_ce;
    logic                  r_run_mode;
    logic                  r_halted;
    logic [CNT_WIDTH-1:0]  r_step_count;
    logic                  w_step_edge;
    logic                  w_mode_edge;
    logic                  w_rep_fire;

    edge_detect u_step_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (btn_step),
        .o_edge  (w_step_edge)
    );

    edge_detect u_mode_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (btn_mode),
        .o_edge  (w_mode_edge)
    );

`ifdef STEP_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // r_rep_cnt counts held cycles since the last pulse; r_rep_active switches the
    // target from the initial delay to the repeat period after the first repeat.
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_active;

    assign w_rep_fire = (r_state == STEP) && btn_step && !w_step_edge &&
                        (r_rep_active ? (r_rep_cnt == REP_W'(REPEAT_PERIOD))
                                      : (r_rep_cnt == REP_W'(REPEAT_DELAY)));

    always_ff @(posedge clk) begin
        if (rst || (r_state != STEP) || !btn_step) begin
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
        end else if (w_step_edge) begin
            r_rep_cnt    <= REP_W'(1);
            r_rep_active <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt    <= REP_W'(1);
            r_rep_active <= 1'b1;
        end else begin
            r_rep_cnt    <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Priority inside each state: halt, then mode toggle, then step/terminal count.
    always_comb begin
        w_next_state = r_state;
        w_div_next   = r_div;
        w_pulse      = 1'b0;
        case (r_state)
            STEP: begin
                if (halt_in) begin
                    w_next_state = HALTED;
                end else if (w_mode_edge) begin
                    w_next_state = RUN;
                    w_div_next   = '0;
                end else if (w_step_edge || w_rep_fire) begin
                    w_pulse = 1'b1;
                end
            end
            RUN: begin
                if (halt_in) begin
                    w_next_state = HALTED;
                    w_div_next   = '0;
                end else if (w_mode_edge) begin
                    w_next_state = STEP;
                    w_div_next   = '0;
                end else if (r_div == DIV_TC) begin
                    w_pulse    = 1'b1;
                    w_div_next = '0;
                end else begin
                    w_div_next = r_div + DIV_WIDTH'(1);
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = STEP;
                w_div_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= STEP;
            r_div        <= '0;
            r_cpu_ce     <= 1'b0;
            r_run_mode   <= 1'b0;
            r_halted     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_div      <= w_div_next;
            r_cpu_ce   <= w_pulse;
            r_run_mode <= (w_next_state == RUN);
            r_halted   <= (w_next_state == HALTED);
            if (w_pulse) begin
                r_step_count <= r_step_count + CNT_WIDTH'(1);
            end
        end
    end

    assign cpu_ce     = r_cpu_ce;
    assign run_mode   = r_run_mode;
    assign halted     = r_halted;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed self-checking bench for cpu_clock_ctrl
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        btn_mode;
    logic        halt_in;
    logic        cpu_ce;
    logic        run_mode;
    logic        halted;
    logic [15:0] step_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_clock_ctrl #(
        .DIV_WIDTH     (24),
        .RUN_DIV       (4),
        .CNT_WIDTH     (16)
`ifdef STEP_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_mode   (btn_mode),
        .halt_in    (halt_in),
        .cpu_ce     (cpu_ce),
        .run_mode   (run_mode),
        .halted     (halted),
        .step_count (step_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        logic exp_ce;

        rst      = 1'b1;
        btn_step = 1'b1;
        btn_mode = 1'b0;
        halt_in  = 1'b0;
        tick(); tick(); tick();
        chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
        chk("rst_run", {31'd0, run_mode}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", {16'd0, step_count}, 32'd0);

        // step button held through reset: no pulse
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_no_ce", {31'd0, cpu_ce}, 32'd0);
        end
        btn_step = 1'b0;
        tick();
        chk("release_no_ce", {31'd0, cpu_ce}, 32'd0);
        btn_step = 1'b1;
        tick();
        chk("step_ce", {31'd0, cpu_ce}, 32'd1);
        chk("step_count1", {16'd0, step_count}, 32'd1);
        tick();
        chk("step_ce_clear", {31'd0, cpu_ce}, 32'd0);
        btn_step = 1'b0;
        tick();

        // run mode: pulses every 4 cycles after entry
        btn_mode = 1'b1;
        tick();
        chk("run_entry", {31'd0, run_mode}, 32'd1);
        chk("run_entry_ce", {31'd0, cpu_ce}, 32'd0);
        btn_mode = 1'b0;
        cnt = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_ce = ((i % 4) == 0);
            if (exp_ce) cnt++;
            chk($sformatf("run_ce_%0d", i), {31'd0, cpu_ce}, {31'd0, exp_ce});
            chk($sformatf("run_cnt_%0d", i), {16'd0, step_count}, cnt);
        end
        chk("run_cnt_final", {16'd0, step_count}, 32'd6);

        // halt coincident with terminal count
        tick(); tick(); tick();
        halt_in = 1'b1;
        tick();
        chk("halt_no_ce", {31'd0, cpu_ce}, 32'd0);
        chk("halt_set", {31'd0, halted}, 32'd1);
        chk("halt_run_clr", {31'd0, run_mode}, 32'd0);
        halt_in  = 1'b0;
        btn_step = 1'b1;
        tick();
        chk("halt_step_ign", {31'd0, cpu_ce}, 32'd0);
        btn_step = 1'b0;
        btn_mode = 1'b1;
        tick();
        chk("halt_mode_ign", {31'd0, cpu_ce}, 32'd0);
        btn_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("halt_quiet", {31'd0, cpu_ce}, 32'd0);
        end
        chk("halt_stays", {31'd0, halted}, 32'd1);
        chk("halt_run", {31'd0, run_mode}, 32'd0);
        chk("halt_count", {16'd0, step_count}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_halted", {31'd0, halted}, 32'd0);
        chk("post_rst_run", {31'd0, run_mode}, 32'd0);
        chk("post_rst_count", {16'd0, step_count}, 32'd0);
        tick();

        // simultaneous mode and step edges in STEP
        btn_mode = 1'b1;
        btn_step = 1'b1;
        tick();
        chk("simul_run", {31'd0, run_mode}, 32'd1);
        chk("simul_no_ce", {31'd0, cpu_ce}, 32'd0);
        tick();
        chk("simul_no_ce2", {31'd0, cpu_ce}, 32'd0);
        btn_mode = 1'b0;
        btn_step = 1'b0;
        tick();
        btn_mode = 1'b1;
        tick();
        chk("back_to_step", {31'd0, run_mode}, 32'd0);
        chk("back_no_ce", {31'd0, cpu_ce}, 32'd0);
        btn_mode = 1'b0;
        tick();
        chk("back_count", {16'd0, step_count}, 32'd0);

        // wrap of step_count
        force dut.r_step_count = 16'hFFFF;
        tick();
        release dut.r_step_count;
        tick();
        chk("preload", {16'd0, step_count}, 32'h0000FFFF);
        btn_step = 1'b1;
        tick();
        chk("wrap_ce", {31'd0, cpu_ce}, 32'd1);
        chk("wrap_count", {16'd0, step_count}, 32'd0);
        btn_step = 1'b0;
        tick();
        tick();

        // held step button: auto-repeat only when the feature is built
        btn_step = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef STEP_AUTOREPEAT_EN
            exp_ce = (i == 1) || (i == 9) || (i == 12) || (i == 15) || (i == 18);
`else
            exp_ce = (i == 1);
`endif
            if (exp_ce) cnt++;
            chk($sformatf("hold_ce_%0d", i), {31'd0, cpu_ce}, {31'd0, exp_ce});
        end
        chk("hold_count", {16'd0, step_count}, cnt);
        btn_step = 1'b0;
        tick();
        chk("release_ce", {31'd0, cpu_ce}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
